// File: rtl/tx_frame_sched.sv
// tx_frame_sched
//    Arbitrates two byte-stream sources (s0: protocol reply, s1: telemetry)
//    onto a single UART transmitter. A granted source keeps the line for its
//    whole frame; each frame is followed by an enforced line-silence gap.
//    A granted source that stalls mid-frame is dropped after TIMEOUT cycles.
//
// Parameters
//    GAP_CYCLES  idle cycles enforced after every frame end or abort
//    TIMEOUT     max cycles a granted source may hold valid low in LOAD
//
// Ports
//    clk, rst                         clock, synchronous active-high reset
//    sN_req/valid/data/last           source N frame request and byte stream
//    sN_ready                         one-cycle pulse: source N byte taken
//    tx_data, tx_start, tx_busy       UART transmitter handshake
//    gnt                              one-hot current grant (00 = none)
//    frame_done, abort                one-cycle frame completion / drop pulses
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | no grant; arbitrate pending requests
// LOAD      | wait for a byte from the granted source, run stall timer
// START     | pulse tx_start and sN_ready for the captured byte
// WAIT_BUSY | wait for the transmitter to report busy
// WAIT_DONE | wait for the transmitter to finish the byte
// GAP       | enforced line silence after a frame end or abort
module tx_frame_sched #(
   parameter int GAP_CYCLES = 30380,
   parameter int TIMEOUT    = 65535
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       s0_req,
   input  logic       s0_valid,
   input  logic [7:0] s0_data,
   input  logic       s0_last,
   output logic       s0_ready,
   input  logic       s1_req,
   input  logic       s1_valid,
   input  logic [7:0] s1_data,
   input  logic       s1_last,
   output logic       s1_ready,
   output logic [7:0] tx_data,
   output logic       tx_start,
   input  logic       tx_busy,
   output logic [1:0] gnt,
   output logic       frame_done,
   output logic       abort
);

   // Counters only ever hold 0 .. LAST, so they need just enough bits for LAST.
   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      START,
      WAIT_BUSY,
      WAIT_DONE,
      GAP
   } state_t;

   state_t           state, state_nx;
   logic [1:0]       gnt_q, gnt_nx;
   logic             last_src, last_src_nx;     // 1: source 1 was granted most recently
   logic             last_flag, last_flag_nx;
   logic [7:0]       tx_data_q, tx_data_nx;
   logic [GAP_W-1:0] gap_cnt, gap_cnt_nx;
   logic [TO_W-1:0]  to_cnt, to_cnt_nx;
   logic             done_q, done_nx;
   logic             abort_q, abort_nx;

   logic             sel_valid;
   logic [7:0]       sel_data;
   logic             sel_last;

   assign sel_valid = gnt_q[1] ? s1_valid : s0_valid;
   assign sel_data  = gnt_q[1] ? s1_data  : s0_data;
   assign sel_last  = gnt_q[1] ? s1_last  : s0_last;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         gnt_q     <= 2'b00;
         last_src  <= 1'b1;
         last_flag <= 1'b0;
         tx_data_q <= 8'h00;
         gap_cnt   <= '0;
         to_cnt    <= '0;
         done_q    <= 1'b0;
         abort_q   <= 1'b0;
      end else begin
         state     <= state_nx;
         gnt_q     <= gnt_nx;
         last_src  <= last_src_nx;
         last_flag <= last_flag_nx;
         tx_data_q <= tx_data_nx;
         gap_cnt   <= gap_cnt_nx;
         to_cnt    <= to_cnt_nx;
         done_q    <= done_nx;
         abort_q   <= abort_nx;
      end
   end

   always_comb begin
      state_nx     = state;
      gnt_nx       = gnt_q;
      last_src_nx  = last_src;
      last_flag_nx = last_flag;
      tx_data_nx   = tx_data_q;
      // Counters fall back to zero outside their own state, so every entry
      // into LOAD or GAP starts counting from 0.
      gap_cnt_nx   = '0;
      to_cnt_nx    = '0;
      done_nx      = 1'b0;
      abort_nx     = 1'b0;

      case (state)
         IDLE: begin
            if (s0_req && s1_req) begin
               // Tie: the source not granted last wins.
               gnt_nx      = last_src ? 2'b01 : 2'b10;
               last_src_nx = ~last_src;
               state_nx    = LOAD;
            end else if (s0_req) begin
               gnt_nx      = 2'b01;
               last_src_nx = 1'b0;
               state_nx    = LOAD;
            end else if (s1_req) begin
               gnt_nx      = 2'b10;
               last_src_nx = 1'b1;
               state_nx    = LOAD;
            end
         end

         LOAD: begin
            if (sel_valid) begin
               tx_data_nx   = sel_data;
               last_flag_nx = sel_last;
               state_nx     = START;
            end else if (to_cnt == TO_LAST) begin
               abort_nx = 1'b1;
               gnt_nx   = 2'b00;
               state_nx = GAP;
            end else begin
               to_cnt_nx = to_cnt + TO_W'(1);
            end
         end

         START: begin
            state_nx = WAIT_BUSY;
         end

         WAIT_BUSY: begin
            if (tx_busy) begin
               state_nx = WAIT_DONE;
            end
         end

         WAIT_DONE: begin
            if (!tx_busy) begin
               if (last_flag) begin
                  done_nx  = 1'b1;
                  gnt_nx   = 2'b00;
                  state_nx = GAP;
               end else begin
                  state_nx = LOAD;
               end
            end
         end

         GAP: begin
            if (gap_cnt == GAP_LAST) begin
               state_nx = IDLE;
            end else begin
               gap_cnt_nx = gap_cnt + GAP_W'(1);
            end
         end

         default: begin
            state_nx = IDLE;
            gnt_nx   = 2'b00;
         end
      endcase
   end

   // START is only reachable from a LOAD capture, so the ready pulse lands
   // exactly one cycle after the byte was taken.
   assign tx_start   = (state == START);
   assign s0_ready   = (state == START) && gnt_q[0];
   assign s1_ready   = (state == START) && gnt_q[1];
   assign tx_data    = tx_data_q;
   assign gnt        = gnt_q;
   assign frame_done = done_q;
   assign abort      = abort_q;

endmodule

// File: doc/tx_frame_sched.md
TX_FRAME_SCHED -- requirements
Module: tx_frame_sched

Interface
REQ-001 Parameter GAP_CYCLES, default 30380: idle clk cycles enforced after each frame ends or aborts (3.5-character silence at 115200 baud).
REQ-002 Parameter TIMEOUT, default 65535: max clk cycles a granted source may leave valid low mid-frame.
REQ-003 Ports, one per line (name, direction, width, meaning):
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- s0_req  in  1  source 0 (protocol reply) has a frame pending; level.
- s0_valid  in  1  source 0 byte available.
- s0_data  in  8  source 0 byte.
- s0_last  in  1  source 0 byte is the final byte of its frame.
- s0_ready  out  1  one-cycle pulse: source 0 byte accepted.
- s1_req, s1_valid, s1_data[7:0], s1_last, s1_ready  same as source 0, for source 1 (telemetry).
- tx_data  out  8  byte presented to the UART transmitter.
- tx_start  out  1  one-cycle pulse: start sending tx_data.
- tx_busy  in  1  UART transmitter busy; high while a byte is shifting out.
- gnt  out  2  one-hot current grant; 00 when none.
- frame_done  out  1  one-cycle pulse: granted frame's last byte fully sent.
- abort  out  1  one-cycle pulse: granted frame dropped on timeout.

Function
REQ-004 State machine states: IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE, GAP.
REQ-005 IDLE, any sN_req=1: gnt set next cycle, state goes to LOAD.
- Arbitration is round-robin. The source not granted last wins a tie.
- A single requester wins regardless of history.
REQ-006 Grant is held for the whole frame. The other source's req is ignored until the frame ends or aborts.
REQ-007 LOAD, granted valid=1:
- next cycle: granted sN_ready=1 for exactly one cycle;
- tx_data latches sN_data; internal last flag latches sN_last;
- state goes to START.
REQ-008 The non-granted sN_ready stays 0 at all times.
REQ-009 START: tx_start=1 for one cycle, then state goes to WAIT_BUSY. tx_data is held stable from START until the next LOAD capture.
REQ-010 WAIT_BUSY: leave for WAIT_DONE on tx_busy=1. WAIT_DONE: leave on tx_busy=0.
REQ-011 Leaving WAIT_DONE:
- last flag=0: return to LOAD.
- last flag=1: frame_done=1 for one cycle, gnt goes to 00, state goes to GAP.
REQ-012 Byte-to-byte latency: the next source byte is not accepted until the prior byte's tx_busy has fallen. At most one byte is outstanding.
REQ-013 GAP:
- counter starts at 0 on entry and increments each cycle;
- exit to IDLE on the cycle after it reaches GAP_CYCLES-1, so GAP lasts exactly GAP_CYCLES cycles;
- requests are ignored during GAP.
REQ-014 Timeout counter clears on LOAD entry and increments each LOAD cycle while the granted valid=0.
- On reaching TIMEOUT: abort=1 for one cycle, gnt goes to 00, state goes to GAP.
- No sN_ready is issued on that cycle.
REQ-015 A granted sN_req drop mid-frame is ignored; only last or timeout ends the frame.
REQ-016 tx_busy already 1 when START issues: WAIT_BUSY exits on the next cycle. Bytes are never lost.
REQ-017 Counters are wide enough for their parameters with no wrap. GAP_CYCLES=0 makes GAP last one cycle.
REQ-018 frame_done and abort are never asserted in the same cycle.

Reset
REQ-019 rst=1 at any clock edge, including mid-frame, forces:
- state IDLE; all counters 0; last flag 0; last-granted pointer = source 1, so source 0 wins the first tie;
- outputs: tx_data=8'h00, tx_start=0, s0_ready=0, s1_ready=0, gnt=00, frame_done=0, abort=0.
REQ-020 No gap is enforced after reset. An in-progress UART byte is not waited for.

Verification (GAP_CYCLES=8, TIMEOUT=16)
REQ-021 Single frame: s0 sends 01 00 10 00 (last on 00), UART model busy 10 cycles/byte
- tx_data sequence 01,00,10,00; 4 tx_start pulses; 4 s0_ready pulses;
- one frame_done; gnt=01 throughout; next grant no sooner than 8 cycles after frame_done.
REQ-022 Tie: s0_req and s1_req rise together, each with a 2-byte frame
- s0 first, then s1 after gap; repeated tie: s1 wins (round-robin alternates).
REQ-023 Lockout: s1_req rises mid s0 frame
- s1_ready stays 0 until s0 frame_done plus 8 gap cycles; no interleaved bytes.
REQ-024 Timeout: s0 granted, sends 1 byte (last=0), then valid held 0
- abort pulses 16 cycles into LOAD; gnt=00; no frame_done; s1 granted after gap.
REQ-025 Reset mid-frame: rst=1 for 1 cycle during WAIT_DONE of byte 2
- all outputs 0 next cycle; after release, a pending tie grants s0 immediately (no gap).
REQ-026 Fast UART: tx_busy=1 already at START
- no lost or duplicated bytes; per-byte sequence START, WAIT_BUSY, WAIT_DONE, LOAD holds.
